// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_WR prioritised write ports, NUM_RD combinational
// read ports with optional same-cycle bypass, and a hardware clear after reset.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stallW,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   wa,
  input  logic [NUM_WR*DATA_W-1:0]   wd,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  output logic                       init_busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   rf [DEPTH];
  logic [NUM_WR-1:0]   wr_eff;

  // A write only counts in RUN, when not stalled, and never to r0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_eff = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      wr_eff[k] = we[k] && !stallW && (wa[k*ADDR_W +: ADDR_W] != '0) && (state == RUN);
    end
  end

  // Clear-sequence state and pointer; restarts from entry 1 on every reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
      ptr   <= ADDR_W'(1);
    end else begin
      state <= state_nxt;
      if (state == CLEAR) ptr <= ptr + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    init_busy = (state == CLEAR);
    case (state)
      CLEAR:   if (ptr == '1) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // NOTE: the storage array has no reset; the clear sequence zeroes it instead,
  // which keeps it mappable to plain RAM/flop arrays without a reset tree.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      rf[ptr] <= '0;
    end else begin
      // NOTE: ascending loop with non-blocking writes: the last (highest-index,
      // youngest) port assigned to an address is the value that commits.
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_eff[k]) rf[wa[k*ADDR_W +: ADDR_W]] <= wd[k*DATA_W +: DATA_W];
      end
    end
  end

  // Reads: array value, overridden by the youngest matching effective write
  // when bypassing; forced to zero for r0 and while clearing.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] val;
    rd  = '0;
    a   = '0;
    val = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      a   = ra[j*ADDR_W +: ADDR_W];
      val = rf[a];
      if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_eff[k] && (wa[k*ADDR_W +: ADDR_W] == a)) val = wd[k*DATA_W +: DATA_W];
        end
      end
      if ((state != RUN) || (a == '0)) val = '0;
      rd[j*DATA_W +: DATA_W] = val;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance
// share stimulus; expected read values are queued at drive time and checked on sample.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;

  logic             clk;
  logic             rst;
  logic             stallW;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wa;
  logic [NW*DW-1:0] wd;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd_b1, rd_b0;
  logic             busy_b1, busy_b0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst(rst), .stallW(stallW), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd_b1), .init_busy(busy_b1)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst(rst), .stallW(stallW), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd_b0), .init_busy(busy_b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          dut;   // 1 = bypassing instance, 0 = non-bypassing
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input bit dut, input int port, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.dut = dut; e.port = port; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic expect_both(input string tag, input int port, input logic [31:0] exp);
    expect_rd({tag, "_b1"}, 1'b1, port, exp);
    expect_rd({tag, "_b0"}, 1'b0, port, exp);
  endtask

  task automatic compare_sb();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = e.dut ? rd_b1[e.port*DW +: DW] : rd_b0[e.port*DW +: DW];
      check($sformatf("%s_p%0d", e.tag, e.port), obs, e.exp);
    end
  endtask

  task automatic idle();
    we = '0; stallW = 1'b0; wa = '0; wd = '0; ra = '0;
  endtask

  task automatic set_w(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[k] = 1'b1;
    wa[k*AW +: AW] = a;
    wd[k*DW +: DW] = d;
  endtask

  task automatic set_r(input int j, input logic [AW-1:0] a);
    ra[j*AW +: AW] = a;
  endtask

  task automatic new_cycle();
    @(negedge clk);
    idle();
  endtask

  // Hold reset low, checking outputs are forced while it is asserted.
  task automatic hold_reset(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      new_cycle();
      rst = 1'b0;
      set_r(0, 5'd3); set_r(1, 5'd7); set_r(2, 5'd9); set_r(3, 5'd12);
      #1;
      check({tag, "_busy"}, busy_b1, 1);
      for (int j = 0; j < NR; j++) expect_both({tag, "_rd"}, j, 32'h0);
      compare_sb();
    end
  endtask

  // Release reset and count busy cycles, reading and writing during the clear.
  task automatic run_clear(input string tag);
    int cnt;
    cnt = 0;
    new_cycle();
    rst = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) new_cycle();
      for (int j = 0; j < NR; j++) set_r(j, 5'((c*4 + j) % 31 + 1));
      if (c == 3) set_w(0, 5'd5, 32'hAAAA_0001);
      #1;
      if (!busy_b1) break;
      cnt++;
      for (int j = 0; j < NR; j++) expect_both({tag, "_rd_busy"}, j, 32'h0);
      compare_sb();
    end
    check({tag, "_busy_cycles"}, cnt, 31);
    check({tag, "_busy_b0_done"}, busy_b0, 0);
  endtask

  task automatic scenario4(input string tag);
    new_cycle();
    set_w(1, 5'd12, 32'h0000_0012);           // establish the old r12 value
    new_cycle();
    set_w(1, 5'd12, 32'h0000_00C0);
    set_r(2, 5'd12);
    expect_rd({tag, "_byp_b1"}, 1'b1, 2, 32'h0000_00C0);
    expect_rd({tag, "_byp_b0"}, 1'b0, 2, 32'h0000_0012);
    #1 compare_sb();
    new_cycle();
    set_r(2, 5'd12);
    expect_both({tag, "_after"}, 2, 32'h0000_00C0);
    #1 compare_sb();
    new_cycle();
    stallW = 1'b1;
    set_w(1, 5'd12, 32'h5555_5555);
    set_r(2, 5'd12);
    expect_both({tag, "_stall_same"}, 2, 32'h0000_00C0);
    #1 compare_sb();
    new_cycle();
    set_r(2, 5'd12);
    expect_both({tag, "_stall_next"}, 2, 32'h0000_00C0);
    #1 compare_sb();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    idle();

    // 1. Reset, clear sequence, discarded write to r5 during the clear.
    hold_reset("rst1", 3);
    run_clear("clear1");
    for (int g = 0; g < 8; g++) begin
      new_cycle();
      for (int j = 0; j < NR; j++) begin
        if (g*4 + j + 1 <= 31) begin
          set_r(j, 5'(g*4 + j + 1));
          expect_both("post_clear", j, 32'h0);
        end
      end
      #1 compare_sb();
    end

    // 2. Dual write to distinct addresses.
    new_cycle();
    set_w(0, 5'd3, 32'h1111_1111);
    set_w(1, 5'd7, 32'h2222_2222);
    new_cycle();
    set_r(0, 5'd3); set_r(1, 5'd7);
    expect_both("dual_r3", 0, 32'h1111_1111);
    expect_both("dual_r7", 1, 32'h2222_2222);
    #1 compare_sb();

    // 3. Conflict on r9: port 1 wins.
    new_cycle();
    set_w(0, 5'd9, 32'hDEAD_0000);
    set_w(1, 5'd9, 32'hBEEF_0001);
    new_cycle();
    set_r(3, 5'd9); set_r(0, 5'd3);
    expect_both("conflict_r9", 3, 32'hBEEF_0001);
    expect_both("conflict_r3_kept", 0, 32'h1111_1111);
    #1 compare_sb();

    // 4. Bypass and stalled write.
    scenario4("s4a");

    // 5. Zero register.
    new_cycle();
    set_w(0, 5'd0, 32'hFFFF_FFFF);
    set_w(1, 5'd0, 32'hFFFF_FFFF);
    for (int j = 0; j < NR; j++) expect_both("r0_same", j, 32'h0);
    #1 compare_sb();
    new_cycle();
    for (int j = 0; j < NR; j++) expect_both("r0_next", j, 32'h0);
    #1 compare_sb();

    // 6. Reset during RUN, then a reset pulse at clear cycle 10.
    hold_reset("rst2", 2);
    new_cycle();
    rst = 1'b1;
    repeat (10) @(negedge clk);
    hold_reset("rst3", 1);
    run_clear("clear2");
    new_cycle();
    set_r(0, 5'd3); set_r(1, 5'd7); set_r(2, 5'd9); set_r(3, 5'd12);
    for (int j = 0; j < NR; j++) expect_both("reclear", j, 32'h0);
    #1 compare_sb();
    scenario4("s4b");

    new_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the dual-issue pipeline. It replaces the single-write, two-read register file. It provides NUM_RD combinational read ports and NUM_WR write ports with defined write-conflict priority, optional write-to-read bypass, and a hardware clear sequence after reset. It sits between decode (read ports) and writeback (write ports), and honours the writeback stall.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W entries
NUM_RD, 4, number of read ports (2 per issue slot)
NUM_WR, 2, number of write ports; higher index = younger instruction
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array contents only

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
stallW  in  1  writeback stall; 1 = suppress all writes this cycle
we  in  NUM_WR  per-port write enable
wa  in  NUM_WR*ADDR_W  write addresses; port k in bits [k*ADDR_W +: ADDR_W]
wd  in  NUM_WR*DATA_W  write data; port k in bits [k*DATA_W +: DATA_W]
ra  in  NUM_RD*ADDR_W  read addresses, packed as for wa
rd  out  NUM_RD*DATA_W  read data, packed as for wd; combinational
init_busy  out  1  1 while the clear sequence runs; the pipeline must hold decode while it is 1

Behaviour:
- Entry 0 is hardwired zero. Writes to address 0 are discarded. Reads of address 0 return 0 in every state and mode.
- Effective write, port k: we[k] & ~stallW & (wa_k != 0) & (state == RUN).
- Write timing: an effective write updates the entry on the rising edge. It is visible in the array from the next cycle.
- Write conflict: if two or more effective writes target the same address in one cycle, the highest-index port wins. Lower-index writes to that address are dropped. Writes to distinct addresses all commit in the same cycle.
- Read, BYPASS=0: rd_j = rf[ra_j].
- Read, BYPASS=1: if any effective write matches ra_j (ra_j != 0), rd_j = wd of the highest-index matching port; otherwise rd_j = rf[ra_j].
- Bypass and stall: stalled writes (stallW=1) are not bypassed.
- FSM states: CLEAR, RUN.
- Reset: rst=0 asynchronously forces state=CLEAR, clear pointer ptr=1, init_busy=1. Array contents are not reset asynchronously.
- CLEAR, per cycle while rst=1: write 0 to rf[ptr], then ptr <= ptr+1.
  - When ptr == 2**ADDR_W-1 is written, the next state is RUN and init_busy <= 0.
  - Clear duration is 2**ADDR_W-1 cycles after reset release (31 at defaults).
  - While in CLEAR: all external writes are ignored and not bypassed, and all rd outputs return 0.
- Reset mid-CLEAR or mid-RUN: the sequence restarts from ptr=1. Values written before the reset are not guaranteed until the clear completes.
- ptr is ADDR_W bits wide; wrap to 0 never occurs because the terminal count exits to RUN.
- Outputs under reset: init_busy=1 and all rd=0 throughout reset assertion.
- Width: no arithmetic on data. Data passes through unmodified at DATA_W bits.

Test Plan:
1. Clear sequence: assert rst=0 for 3 cycles, release. Required: init_busy=1 for exactly 31 cycles, then 0. Reads of r1..r31 return 0 during and after the clear. A write with we=2'b01, wa0=5, wd0=32'hAAAA_0001 issued during CLEAR is discarded: r5=0 after the clear.
2. Dual write: we=2'b11, wa0=3, wd0=32'h1111_1111, wa1=7, wd1=32'h2222_2222. Required: next cycle r3=32'h1111_1111 and r7=32'h2222_2222.
3. Conflict: both ports write r9; wd0=32'hDEAD_0000, wd1=32'hBEEF_0001. Required: r9=32'hBEEF_0001.
4. Bypass (BYPASS=1): same cycle, we=2'b10, wa1=12, wd1=32'h0000_00C0, ra2=12. Required: rd2=32'h0000_00C0 combinationally in that cycle. Repeat with stallW=1: rd2 keeps the old r12 value and the array is unchanged next cycle.
5. Zero register: write r0 with 32'hFFFF_FFFF on both ports, and read r0 on all 4 ports in the same and next cycle. Required: all reads return 0.
6. Reset mid-clear: pulse rst=0 at clear cycle 10. Required: init_busy stays 1 for a further 31 cycles from the new release. Repeat with BYPASS=0 and scenario 4 is rerun: rd2 returns the old r12 value in the write cycle and 32'h0000_00C0 next cycle.
